// File: rtl/sprite_pkg.sv
// ============================================================================
//  Module   : sprite_pkg
//  Purpose  : Shared definitions for the sprite layer: command word field
//             positions, info/type codes, pattern and sprite state records,
//             and the pixels-per-ROM-word helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_pkg;

  // Command word layout
  localparam int CMD_SUB_LO   = 26;
  localparam int CMD_CHILD_LO = 21;
  localparam int CMD_INFO_LO  = 17;
  localparam int CMD_TYPE_LO  = 14;
  localparam int CMD_PP_BIT   = 13;

  // Info codes
  localparam logic [3:0] INFO_WRITE = 4'h1;
  localparam logic [3:0] INFO_SWAP  = 4'hF;

  // State-write type codes
  localparam logic [2:0] TYPE_CTRL  = 3'b001;
  localparam logic [2:0] TYPE_X     = 3'b010;
  localparam logic [2:0] TYPE_Y     = 3'b011;
  localparam logic [2:0] TYPE_SHIFT = 3'b100;

  localparam int PATTERN_BITS = 36;

  typedef struct packed {
    logic [15:0] base;
    logic [9:0]  w;
    logic [9:0]  h;
  } pattern_t;

  typedef struct packed {
    logic       visible;
    logic       flip;
    logic [4:0] pattern;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] shift;
  } sprite_state_t;

  function automatic int pix_per_word(input int mem_width, input int bpp);
    return mem_width / bpp;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_layer_if.sv
// ============================================================================
//  Module   : sprite_layer_if
//  Purpose  : Command bus plus VGA position/pixel signals of the sprite layer.
//  Signals  : write, writedata[31:0]   command strobe and word
//             hcount, vcount [9:0]     pixel position from the VGA counter
//             RGB_output[23:0]         rendered pixel colour
//             swap_pending, front      buffer swap status
//  Modports : master (drives commands/position), slave (the sprite layer)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sprite_layer_if;
  logic        write;
  logic [31:0] writedata;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [23:0] RGB_output;
  logic        swap_pending;
  logic        front;

  modport master (output write, writedata, hcount, vcount,
                  input  RGB_output, swap_pending, front);
  modport slave  (input  write, writedata, hcount, vcount,
                  output RGB_output, swap_pending, front);
endinterface

`default_nettype wire

// File: rtl/sprite_addr_gen.sv
// ============================================================================
//  Module   : sprite_addr_gen
//  Purpose  : Combinational per-sprite hit test and ROM {word, lane} address.
//  Ports    : state_i    sprite state of the displayed buffer
//             pat_i      pattern entry selected by state_i.pattern
//             hcount_i   pixel column
//             vcount_i   pixel line
//             hit_o      visible, inside the sprite box and inside the ROM
//             word_o     ROM word address
//             lane_o     pixel lane within the ROM word (lane 0 = LSBs)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int MEM_WORDS   = 128,
  parameter int MEM_WIDTH   = 4,
  parameter int BPP         = 2,
  parameter int PATTERN_NUM = 2,
  parameter int ADDR_W      = 7,
  parameter int LANE_W      = 1
) (
  input  sprite_state_t     state_i,
  input  pattern_t          pat_i,
  input  logic [9:0]        hcount_i,
  input  logic [9:0]        vcount_i,
  output logic              hit_o,
  output logic [ADDR_W-1:0] word_o,
  output logic [LANE_W-1:0] lane_o
);

  localparam int PPW = pix_per_word(MEM_WIDTH, BPP);

  logic        in_x, in_y, in_mem, pat_ok;
  logic [10:0] x_end, y_end;
  logic [9:0]  dx, dy;
  logic [10:0] col_sum;
  logic [9:0]  col_raw, col;
  logic [15:0] pix, word_full;

  // 11-bit sums keep a sprite near the right/bottom edge from wrapping to 0.
  assign x_end = {1'b0, state_i.x} + {1'b0, pat_i.w};
  assign y_end = {1'b0, state_i.y} + {1'b0, pat_i.h};
  assign in_x  = (hcount_i >= state_i.x) && ({1'b0, hcount_i} < x_end);
  assign in_y  = (vcount_i >= state_i.y) && ({1'b0, vcount_i} < y_end);

  assign dx      = hcount_i - state_i.x;
  assign dy      = vcount_i - state_i.y;
  assign col_sum = {1'b0, dx} + {1'b0, state_i.shift};
  // Zero-width patterns never hit; the guard only avoids a divide by zero.
  assign col_raw = (pat_i.w == 10'd0) ? 10'd0 : 10'(col_sum % {1'b0, pat_i.w});
  assign col     = state_i.flip ? (pat_i.w - 10'd1 - col_raw) : col_raw;

  assign pix       = pat_i.base + 16'({10'b0, dy} * {10'b0, pat_i.w}) + {6'b0, col};
  assign word_full = pix / 16'(PPW);
  assign in_mem    = {16'b0, word_full} < 32'(MEM_WORDS);
  assign pat_ok    = {27'b0, state_i.pattern} < 32'(PATTERN_NUM);

  assign hit_o  = state_i.visible && in_x && in_y && in_mem && pat_ok;
  assign word_o = ADDR_W'(word_full);
  assign lane_o = LANE_W'(pix % 16'(PPW));

endmodule

`default_nettype wire

// File: rtl/sprite_layer.sv
// ============================================================================
//  Module   : sprite_layer
//  Purpose  : Ping-pong sprite state decoded from 32-bit commands, frame-
//             boundary buffer swap, and a 2-stage pattern-ROM pixel renderer.
//  Ports    : clk     the single clock
//             reset   synchronous active-high reset
//             bus     sprite_layer_if.slave: write/writedata commands,
//                     hcount/vcount in, RGB_output (2-cycle latency),
//                     swap_pending and front status out
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_layer
  import sprite_pkg::*;
#(
  parameter logic [5:0]  SUB_COMP_ID = 6'd16,
  parameter int          CHILD_NUM   = 4,
  parameter int          PATTERN_NUM = 2,
  parameter int          MEM_WORDS   = 128,
  parameter int          MEM_WIDTH   = 4,
  parameter int          BPP         = 2,
  parameter logic [23:0] BG_COLOR    = 24'h9290ff,
  parameter logic [9:0]  SWAP_LINE   = 10'd480,
  // Entry p at [p*36 +: 36] = {base[15:0], W[9:0], H[9:0]}
  parameter logic [PATTERN_NUM*PATTERN_BITS-1:0] PATTERN_TABLE =
    {16'd128, 10'd16, 10'd8, 16'd0, 10'd32, 10'd4},
  // Entry i at [i*24 +: 24]; entry 0 is never shown (transparent)
  parameter logic [(2**BPP)*24-1:0] PALETTE =
    {24'hffff00, 24'h0000ff, 24'hff0000, 24'h000000},
  // ROM image, word i at [i*MEM_WIDTH +: MEM_WIDTH]
  parameter logic [MEM_WORDS*MEM_WIDTH-1:0] MEM_INIT = '0
) (
  input  logic          clk,
  input  logic          reset,
  sprite_layer_if.slave bus
);

  localparam int PPW    = pix_per_word(MEM_WIDTH, BPP);
  localparam int ADDR_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;

  // ---------------- command decode and sprite state ----------------
  sprite_state_t st_q [2][CHILD_NUM];
  sprite_state_t st_d [2][CHILD_NUM];
  logic front_q, front_d, pend_q, pend_d, target_q, target_d;
  logic swap_exec;

  logic [5:0] cmd_sub;
  logic [4:0] cmd_child;
  logic [3:0] cmd_info;
  logic [2:0] cmd_type;
  logic       cmd_pp;

  assign cmd_sub   = bus.writedata[CMD_SUB_LO   +: 6];
  assign cmd_child = bus.writedata[CMD_CHILD_LO +: 5];
  assign cmd_info  = bus.writedata[CMD_INFO_LO  +: 4];
  assign cmd_type  = bus.writedata[CMD_TYPE_LO  +: 3];
  assign cmd_pp    = bus.writedata[CMD_PP_BIT];

  assign swap_exec = pend_q && (bus.vcount == SWAP_LINE) && (bus.hcount == 10'd0);

  always_comb begin
    st_d     = st_q;
    front_d  = front_q;
    pend_d   = pend_q;
    target_d = target_q;

    // Clear first so a same-cycle visible=1 write below overrides it.
    if (swap_exec) begin
      front_d = target_q;
      pend_d  = 1'b0;
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < CHILD_NUM; c++)
          if (1'(b) != target_q) st_d[b][c].visible = 1'b0;
    end

    // A request arriving on the execution cycle re-arms for the next frame.
    if (bus.write && cmd_info == INFO_SWAP) begin
      pend_d   = 1'b1;
      target_d = cmd_pp;
    end

    if (bus.write && cmd_info == INFO_WRITE && cmd_sub == SUB_COMP_ID) begin
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < CHILD_NUM; c++)
          if (cmd_pp == 1'(b) && cmd_child == 5'(c)) begin
            case (cmd_type)
              TYPE_CTRL: begin
                st_d[b][c].visible = bus.writedata[12];
                st_d[b][c].flip    = bus.writedata[11];
                if ({27'b0, bus.writedata[4:0]} < 32'(PATTERN_NUM))
                  st_d[b][c].pattern = bus.writedata[4:0];
              end
              TYPE_X:     st_d[b][c].x     = bus.writedata[9:0];
              TYPE_Y:     st_d[b][c].y     = bus.writedata[9:0];
              TYPE_SHIFT: st_d[b][c].shift = bus.writedata[9:0];
              default: ;
            endcase
          end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < CHILD_NUM; c++)
          st_q[b][c] <= '0;
      front_q  <= 1'b0;
      pend_q   <= 1'b0;
      target_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      front_q  <= front_d;
      pend_q   <= pend_d;
      target_q <= target_d;
    end
  end

  // ---------------- stage 1: hit test, address, ROM read ----------------
  logic [MEM_WIDTH-1:0] rom   [MEM_WORDS];
  logic                 w_hit [CHILD_NUM];
  logic [ADDR_W-1:0]    w_word[CHILD_NUM];
  logic [LANE_W-1:0]    w_lane[CHILD_NUM];

  for (genvar i = 0; i < MEM_WORDS; i++) begin : g_rom
    assign rom[i] = MEM_INIT[i*MEM_WIDTH +: MEM_WIDTH];
  end

  for (genvar c = 0; c < CHILD_NUM; c++) begin : g_child
    sprite_state_t st_c;
    pattern_t      pat_c;

    assign st_c = st_q[front_q][c];

    always_comb begin
      pat_c = '0;
      for (int p = 0; p < PATTERN_NUM; p++)
        if (st_c.pattern == 5'(p)) pat_c = PATTERN_TABLE[p*PATTERN_BITS +: PATTERN_BITS];
    end

    sprite_addr_gen #(
      .MEM_WORDS  (MEM_WORDS),
      .MEM_WIDTH  (MEM_WIDTH),
      .BPP        (BPP),
      .PATTERN_NUM(PATTERN_NUM),
      .ADDR_W     (ADDR_W),
      .LANE_W     (LANE_W)
    ) u_addr_gen (
      .state_i (st_c),
      .pat_i   (pat_c),
      .hcount_i(bus.hcount),
      .vcount_i(bus.vcount),
      .hit_o   (w_hit[c]),
      .word_o  (w_word[c]),
      .lane_o  (w_lane[c])
    );
  end

  logic                 hit1_q [CHILD_NUM];
  logic [LANE_W-1:0]    lane1_q[CHILD_NUM];
  logic [MEM_WIDTH-1:0] rom1_q [CHILD_NUM];

  always_ff @(posedge clk) begin
    for (int c = 0; c < CHILD_NUM; c++) begin
      if (reset) begin
        hit1_q[c]  <= 1'b0;
        lane1_q[c] <= '0;
        rom1_q[c]  <= '0;
      end else begin
        hit1_q[c]  <= w_hit[c];
        lane1_q[c] <= w_lane[c];
        rom1_q[c]  <= rom[w_word[c]];
      end
    end
  end

  // ---------------- stage 2: lane select, palette, priority ----------------
  logic [BPP-1:0] w_idx[CHILD_NUM];
  logic [23:0]    rgb_d, rgb_q;

  for (genvar c = 0; c < CHILD_NUM; c++) begin : g_lane
    assign w_idx[c] = rom1_q[c][int'(lane1_q[c])*BPP +: BPP];
  end

  // Walk from the highest child down so the lowest opaque index wins.
  always_comb begin
    rgb_d = BG_COLOR;
    for (int c = CHILD_NUM - 1; c >= 0; c--)
      if (hit1_q[c] && w_idx[c] != '0) rgb_d = PALETTE[int'(w_idx[c])*24 +: 24];
  end

  always_ff @(posedge clk) begin
    if (reset) rgb_q <= BG_COLOR;
    else       rgb_q <= rgb_d;
  end

  assign bus.RGB_output   = rgb_q;
  assign bus.swap_pending = pend_q;
  assign bus.front        = front_q;

endmodule

`default_nettype wire
